mux_arbiter_2: RTL and testbench

MUX_ARBITER_2 -- requirements
Module: mux_arbiter_2

---
 rtl/mux_arbiter_2.sv | 111 +++++++++++
 tb/tb_mux_arbiter_2.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter_2.sv
// Two-requester burst arbiter. It alternates priority on release and caps each grant
// at MAX_HOLD beats. The output stage is a single registered beat with valid/ready.
module mux_arbiter_2 #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ReqA,
  input  logic [WIDTH-1:0] DataA,
  input  logic             LastA,
  output logic             AckA,
  input  logic             ReqB,
  input  logic [WIDTH-1:0] DataB,
  input  logic             LastB,
  output logic             AckB,
  output logic [WIDTH-1:0] O,
  output logic             OValid,
  input  logic             OReady,
  output logic             Sel
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_e;

  localparam logic [7:0] HOLD = 8'(MAX_HOLD);

  state_e           state_q, state_d;
  logic             pri_q, pri_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             ovalid_q, ovalid_d;
  logic [7:0]       cnt_q, cnt_d;

  logic       space;
  logic       ack_a, ack_b, ack;
  logic       req_g, last_g, rel_g;
  logic [7:0] cnt_inc;

  assign space  = !ovalid_q || OReady;
  assign ack_a  = (state_q == GRANT_A) && ReqA && space;
  assign ack_b  = (state_q == GRANT_B) && ReqB && space;
  assign ack    = ack_a || ack_b;

  assign AckA   = ack_a;
  assign AckB   = ack_b;
  assign O      = o_q;
  assign OValid = ovalid_q;
  assign Sel    = sel_q;

  always_comb begin
    state_d  = state_q;
    pri_d    = pri_q;
    cnt_d    = cnt_q;
    o_d      = o_q;
    ovalid_d = ovalid_q;
    req_g    = (state_q == GRANT_B) ? ReqB : ReqA;
    last_g   = (state_q == GRANT_B) ? LastB : LastA;
    cnt_inc  = cnt_q + 8'd1;
    rel_g    = 1'b0;

    if (ack) begin
      o_d      = sel_q ? DataB : DataA;
      ovalid_d = 1'b1;
      cnt_d    = cnt_inc;
    end else if (ovalid_q && OReady) begin
      ovalid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (ReqA && (!ReqB || !pri_q)) begin
          state_d = GRANT_A;
          cnt_d   = '0;
        end else if (ReqB) begin
          state_d = GRANT_B;
          cnt_d   = '0;
        end
      end
      GRANT_A, GRANT_B: begin
        // A dropped request releases even before the first beat is taken.
        rel_g = !req_g || (ack && (last_g || cnt_inc == HOLD));
        if (rel_g) begin
          state_d = IDLE;
          pri_d   = (state_q == GRANT_A);
        end
      end
      default: state_d = IDLE;
    endcase

    sel_d = (state_d == GRANT_B);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pri_q    <= 1'b0;
      sel_q    <= 1'b0;
      o_q      <= '0;
      ovalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pri_q    <= pri_d;
      sel_q    <= sel_d;
      o_q      <= o_d;
      ovalid_q <= ovalid_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_arbiter_2.sv
// Self-checking bench for mux_arbiter_2: directed scenarios plus random traffic.
// Checks run against a cycle-level reference model and a data scoreboard.
module tb_mux_arbiter_2;
  localparam int W    = 32;
  localparam int HOLD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ReqA = 1'b0, LastA = 1'b0, ReqB = 1'b0, LastB = 1'b0, OReady = 1'b0;
  logic [W-1:0] DataA = '0, DataB = '0;
  logic         AckA, AckB, OValid, Sel;
  logic [W-1:0] O;

  mux_arbiter_2 #(.WIDTH(W), .MAX_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst),
    .ReqA(ReqA), .DataA(DataA), .LastA(LastA), .AckA(AckA),
    .ReqB(ReqB), .DataB(DataB), .LastB(LastB), .AckB(AckB),
    .O(O), .OValid(OValid), .OReady(OReady), .Sel(Sel)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner 0 = none, 1 = A, 2 = B; pri 0 favours A.
  int           m_owner, m_pri, m_beats;
  logic [W-1:0] m_o;
  bit           m_ov;
  logic [W-1:0] sbq[$];

  bit           seen_a, seen_b, rec_sel, rec_ov;
  logic [W-1:0] rec_o;
  int           cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_pri = 0; m_beats = 0; m_o = '0; m_ov = 1'b0;
    sbq.delete();
  endtask

  task automatic step(input bit ra, input logic [W-1:0] da, input bit la,
                      input bit rb, input logic [W-1:0] db, input bit lb, input bit rdy);
    bit ea, eb, sp, req, last;
    int n_owner, n_pri, n_beats;
    logic [W-1:0] n_o;
    bit n_ov;
    @(negedge clk);
    ReqA = ra; DataA = da; LastA = la;
    ReqB = rb; DataB = db; LastB = lb; OReady = rdy;
    #1;
    sp = !m_ov || rdy;
    ea = (m_owner == 1) && ra && sp;
    eb = (m_owner == 2) && rb && sp;
    check("ack_a", AckA, ea);
    check("ack_b", AckB, eb);
    check("ack_excl", AckA & AckB, 1'b0);
    check("sel", Sel, m_owner == 2);
    check("ovalid", OValid, m_ov);
    check("o", O, m_o);
    if (OValid && rdy) begin
      if (sbq.size() == 0) check("sb_underflow", sbq.size(), 1);
      else check("sb_data", O, sbq.pop_front());
    end
    seen_a = AckA; seen_b = AckB; rec_sel = Sel; rec_ov = OValid; rec_o = O;

    n_owner = m_owner; n_pri = m_pri; n_beats = m_beats; n_o = m_o; n_ov = m_ov;
    if (ea || eb) begin
      n_o  = ea ? da : db;
      n_ov = 1'b1;
      sbq.push_back(n_o);
    end else if (m_ov && rdy) begin
      n_ov = 1'b0;
    end
    if (m_owner == 0) begin
      if (ra && (!rb || m_pri == 0)) begin n_owner = 1; n_beats = 0; end
      else if (rb) begin n_owner = 2; n_beats = 0; end
    end else begin
      req  = (m_owner == 1) ? ra : rb;
      last = (m_owner == 1) ? la : lb;
      if (ea || eb) n_beats = m_beats + 1;
      if (!req || ((ea || eb) && (last || n_beats == HOLD))) begin
        n_owner = 0;
        n_pri   = (m_owner == 1) ? 1 : 0;
      end
    end
    @(posedge clk);
    m_owner = n_owner; m_pri = n_pri; m_beats = n_beats; m_o = n_o; m_ov = n_ov;
    cyc++;
  endtask

  // Reset is raised between edges so the checks see its asynchronous effect.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_sel", Sel, 1'b0);
    check("rst_ovalid", OValid, 1'b0);
    check("rst_o", O, '0);
    check("rst_acka", AckA, 1'b0);
    check("rst_ackb", AckB, 1'b0);
    @(negedge clk);
    ReqA = 0; ReqB = 0; LastA = 0; LastB = 0; OReady = 0;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int ackcyc[10];
    int acked, nxt, k;
    cyc = 0;
    model_reset();
    do_reset();

    // Idle to single beat, then priority has moved to B.
    step(1, 32'hAA, 1, 0, 0, 0, 1);
    check("t1_c0_acka", seen_a, 1'b0);
    step(1, 32'hAA, 1, 0, 0, 0, 1);
    check("t1_c1_acka", seen_a, 1'b1);
    check("t1_c1_sel", rec_sel, 1'b0);
    step(1, 32'hBB, 1, 1, 32'hCC, 1, 1);
    check("t1_c2_o", rec_o, 32'hAA);
    check("t1_c2_ov", rec_ov, 1'b1);
    check("t1_c2_idle", seen_a | seen_b, 1'b0);
    step(1, 32'hBB, 1, 1, 32'hCC, 1, 1);
    check("t1_pri_b", seen_b, 1'b1);

    // Continuous simultaneous requests alternate A, B, A, B.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1, 32'h1000 + i, 1, 1, 32'h2000 + i, 1, 1);
      if (seen_a) order.push_back(1);
      if (seen_b) order.push_back(2);
    end
    check("t2_count", order.size() >= 4, 1'b1);
    if (order.size() >= 4) begin
      check("t2_g0", order[0], 1);
      check("t2_g1", order[1], 2);
      check("t2_g2", order[2], 1);
      check("t2_g3", order[3], 2);
    end

    // Forced release after MAX_HOLD beats, with one idle cycle before regrant.
    do_reset();
    acked = 0; nxt = 1; k = 0;
    while (acked < 10 && k < 40) begin
      step(0, 0, 0, 1, nxt, 0, 1);
      if (seen_b) begin ackcyc[acked] = k; acked++; nxt++; end
      k++;
    end
    check("t3_done", acked, 10);
    if (acked == 10) begin
      check("t3_first_run", ackcyc[3] - ackcyc[0], 3);
      check("t3_bubble", ackcyc[4] - ackcyc[3], 2);
      check("t3_second_run", ackcyc[7] - ackcyc[4], 3);
      check("t3_bubble2", ackcyc[8] - ackcyc[7], 2);
    end

    // Backpressure holds the first beat and blocks further acks.
    do_reset();
    nxt = 32'h100;
    step(1, nxt, 0, 0, 0, 0, 1);
    step(1, nxt, 0, 0, 0, 0, 1);
    check("t4_first_ack", seen_a, 1'b1);
    if (seen_a) nxt++;
    for (int i = 0; i < 3; i++) begin
      step(1, nxt, 0, 0, 0, 0, 0);
      check("t4_hold_o", rec_o, 32'h100);
      check("t4_no_ack", seen_a, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, nxt, 0, 0, 0, 0, 1);
      if (seen_a) nxt++;
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);
    check("t4_drained", sbq.size(), 0);

    // Zero-beat release keeps OValid and flips priority to B.
    do_reset();
    step(0, 0, 0, 1, 32'h55, 1, 1);
    step(0, 0, 0, 1, 32'h55, 1, 1);
    step(1, 32'h66, 0, 0, 0, 0, 0);
    step(0, 32'h66, 0, 0, 0, 0, 0);
    check("t5_no_ack", seen_a, 1'b0);
    step(1, 32'h77, 1, 1, 32'h88, 1, 1);
    check("t5_ov_kept", rec_ov, 1'b1);
    check("t5_o_kept", rec_o, 32'h55);
    step(1, 32'h77, 1, 1, 32'h88, 1, 1);
    check("t5_pri_b", seen_b, 1'b1);

    // Reset in the middle of a B burst clears outputs without a clock edge.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h900 + i, 0, 1);
    check("t6_in_burst", rec_sel, 1'b1);
    do_reset();

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
